debug_trace_buf: RTL and testbench

Capture buffer that sits on the receiving end of the CPU's 16-bit `debug` output bus. It samples the bus every cycle, records each new value together with a free-running cycle timestamp, and queues the entries in a FIFO. A downstream reader (bench monitor, power-trace exporter) drains the FIFO over a valid/ready handshake. Dropped entries are counted, never silently lost.

---
 rtl/debug_trace_pkg.sv | 21 ++
 rtl/trace_fifo.sv | 54 +++++
 rtl/debug_trace_buf.sv | 118 +++++++++++
 tb/tb_debug_trace_buf.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/debug_trace_pkg.sv
// Shared types and default widths for the debug-bus trace capture buffer.
package debug_trace_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefTsW   = 16;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefOvfW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun
  } trace_state_e;

  // Timestamp occupies the MSBs so entries sort naturally by time.
  typedef struct packed {
    logic [DefTsW-1:0]   ts;
    logic [DefDataW-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// Head data is a mux of registered storage; it reads zero while empty.
module trace_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot the simultaneous push reuses, so push is legal when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/debug_trace_buf.sv
// Debug-bus capture buffer: timestamps samples and queues them for a reader.
// Define DBG_TRACE_FILTER_EN for change-only capture; otherwise RUN traces every cycle.
module debug_trace_buf
  import debug_trace_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned TS_W   = DefTsW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned OVF_W  = DefOvfW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      dbg_in,
  input  logic                   cap_en,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_W+TS_W-1:0] rd_data,
  output logic                   full,
  output logic [OVF_W-1:0]       ovf_cnt
);

  localparam logic [TS_W-1:0]  TsOne  = {{(TS_W-1){1'b0}}, 1'b1};
  localparam logic [OVF_W-1:0] OvfOne = {{(OVF_W-1){1'b0}}, 1'b1};
  localparam logic [OVF_W-1:0] OvfMax = {OVF_W{1'b1}};

  trace_state_e     state_q, state_d;
  logic [TS_W-1:0]  ts_q;
  logic [OVF_W-1:0] ovf_q;
  logic             push_req;
  logic             fifo_empty;
  logic             drop;

`ifdef DBG_TRACE_FILTER_EN
  logic [DATA_W-1:0] last_q;
  logic              load_last;

  // last_q tracks every sampled word, including ones dropped on overflow.
  assign load_last = (state_q == StArm) || ((state_q == StRun) && cap_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (load_last) begin
      last_q <= dbg_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cap_en) state_d = StArm;
      StArm:   state_d = StRun;
      StRun:   if (!cap_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    push_req = 1'b0;
    unique case (state_q)
      StArm: push_req = 1'b1;
      StRun: begin
`ifdef DBG_TRACE_FILTER_EN
        push_req = cap_en && (dbg_in != last_q);
`else
        push_req = cap_en;
`endif
      end
      default: push_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TsOne;
    end
  end

  // Full implies rd_valid, so rd_ready alone decides whether a slot frees up.
  assign drop = push_req && full && !rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else if (drop && (ovf_q != OvfMax)) begin
      ovf_q <= ovf_q + OvfOne;
    end
  end

  trace_fifo #(
    .WIDTH(DATA_W + TS_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_req),
    .wdata({ts_q, dbg_in}),
    .pop  (rd_ready),
    .full (full),
    .empty(fifo_empty),
    .rdata(rd_data)
  );

  assign rd_valid = !fifo_empty;
  assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_debug_trace_buf.sv
// Scoreboard bench for debug_trace_buf: a queue-based reference model predicts
// entries, a negedge monitor pops and compares them against the DUT head.
module tb_debug_trace_buf;
  import debug_trace_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned TW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned OW    = 8;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          cap_en   = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] dbg_in   = '0;
  logic          rd_valid;
  logic          full;
  logic [DW+TW-1:0] rd_data;
  logic [OW-1:0] ovf_cnt;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  debug_trace_buf #(
    .DATA_W(DW),
    .TS_W  (TW),
    .DEPTH (DEPTH),
    .OVF_W (OW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dbg_in  (dbg_in),
    .cap_en  (cap_en),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data (rd_data),
    .full    (full),
    .ovf_cnt (ovf_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: capture mode, timestamp and FIFO contents as plain values.
  trace_entry_t exp_q[$];
  int unsigned  m_ts;
  int unsigned  m_ovf;
  int           m_mode;  // 0 idle, 1 armed, 2 running
  logic [DW-1:0] m_last;
  bit           want;
  bit           popped;
  int unsigned  pops_n;
  int unsigned  seen_pops;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ts      = 0;
      m_ovf     = 0;
      m_mode    = 0;
      m_last    = '0;
      seen_pops = pops_n;
    end else begin
      popped    = (pops_n != seen_pops);
      seen_pops = pops_n;
      want      = 1'b0;
      if (m_mode == 0) begin
        if (cap_en) m_mode = 1;
      end else if (m_mode == 1) begin
        want   = 1'b1;
        m_last = dbg_in;
        m_mode = 2;
      end else if (!cap_en) begin
        m_mode = 0;
      end else begin
`ifdef DBG_TRACE_FILTER_EN
        want = (dbg_in != m_last);
`else
        want = 1'b1;
`endif
        m_last = dbg_in;
      end
      if (want) begin
        if (!popped && exp_q.size() == DEPTH) begin
          if (m_ovf < (2 ** OW) - 1) m_ovf++;
        end else begin
          exp_q.push_back('{ts: m_ts[TW-1:0], data: dbg_in});
        end
      end
      m_ts = (m_ts + 1) % (2 ** TW);
    end
  end

  // Monitor: compare head and flags, and pop when a handshake is due.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_valid", 64'(rd_valid), 64'(exp_q.size() != 0));
      chk("full", 64'(full), 64'(exp_q.size() == DEPTH));
      chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
      if (exp_q.size() != 0) begin
        chk("rd_data", 64'(rd_data), 64'(exp_q[0]));
        if (rd_ready) begin
          void'(exp_q.pop_front());
          pops_n++;
        end
      end
    end
  end

  task automatic step(input logic ce, input logic [DW-1:0] d, input logic rr);
    cap_en   = ce;
    dbg_in   = d;
    rd_ready = rr;
    @(posedge clk);
    #1;
  endtask

  // Async reset mid-cycle: queue and overflow count must clear at once.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf_cnt), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] v;
  int unsigned   seq[5] = '{1, 1, 2, 2, 3};

  initial begin
    pops_n = 0;
    #12;
    do_reset("por");

    // Constant word held with capture on.
    for (int i = 0; i < 11; i++) step(1'b1, 16'h00A5, 1'b1);
    chk("a5_ovf", 64'(ovf_cnt), 64'd0);

    // Back to idle, then the 1,1,2,2,3 sequence.
    step(1'b0, 16'h00A5, 1'b1);
    step(1'b0, 16'h00A5, 1'b1);
    step(1'b1, 16'h0001, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, DW'(seq[i]), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0003, 1'b1);

    // Overflow: 20 distinct words, reader stalled.
    do_reset("rst1");
    step(1'b1, 16'd200, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, DW'(200 + i), 1'b0);
    chk("ovf_after_20", 64'(ovf_cnt), 64'd4);
    chk("full_after_20", 64'(full), 64'd1);
    chk("head_first", 64'(rd_data), 64'h0001_00C8);

    // Full with reader ready: pop and push in one cycle, no drop.
    step(1'b1, 16'h0BEE, 1'b1);
    chk("ovf_pushpop", 64'(ovf_cnt), 64'd4);
    chk("full_pushpop", 64'(full), 64'd1);

    // Drain to 5 entries then reset mid-operation.
    for (int i = 0; i < 11; i++) step(1'b0, 16'h0BEE, 1'b1);
    cap_en = 1'b1;
    do_reset("rst2");
    step(1'b1, 16'd300, 1'b0);
    step(1'b1, 16'd301, 1'b0);
    chk("arm_after_rst", 64'(rd_data), {32'd0, 16'd1, 16'd301});
    for (int i = 0; i < 4; i++) step(1'b0, 16'd301, 1'b1);

    // Randomized traffic with stalls and capture toggling.
    for (int i = 0; i < 3000; i++) begin
      step(1'b1 && ($urandom_range(0, 9) != 0), DW'($urandom_range(0, 3)),
           (i % 600 < 120) ? 1'b0 : ($urandom_range(0, 2) != 0));
    end

    // Long run across the timestamp wrap; force changes around it.
    v = 16'h1234;
    for (int i = 0; i < 65600; i++) begin
      if ($urandom_range(0, 63) == 0 || m_ts >= 65530 || m_ts < 6) v = v + 16'd1;
      step(1'b1, v, 1'b1);
    end
    for (int i = 0; i < 20; i++) step(1'b0, v, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
